dunc16_core: RTL and testbench

Accumulator-based 16-bit processor core for the NICNAC16 design, with an internal word-addressed memory. It runs one instruction per fetch/execute major cycle. Phase (T0–T3) and major-state (FETCH/EXECUTE) timing is supplied by an external sequencer. The accumulator and memory-data register are exported for observation, together with the store-instruction write-flag strobes.

---
 rtl/dunc16_pkg.sv | 29 ++
 rtl/dunc16_alu.sv | 25 ++
 rtl/dunc16_core.sv | 110 +++++++++++
 tb/tb_dunc16_core.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dunc16_pkg.sv
// Shared constants for the dunc16 accumulator core: data width, opcode field and opcode set.
package dunc16_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 12;

    typedef enum logic [3:0] {
        OpNop = 4'h0,
        OpLda = 4'h1,
        OpSta = 4'h2,
        OpAdd = 4'h3,
        OpSub = 4'h4,
        OpAnd = 4'h5,
        OpOr  = 4'h6,
        OpNot = 4'h7,
        OpJmp = 4'h8,
        OpJz  = 4'h9,
        OpJn  = 4'hA,
        OpCla = 4'hB
    } opcode_e;

    // Opcodes whose execute T1 loads MD from memory.
    function automatic logic reads_mem(input logic [3:0] op);
        return (op == OpLda) || (op == OpAdd) || (op == OpSub) ||
               (op == OpAnd) || (op == OpOr);
    endfunction

endpackage

// File: rtl/dunc16_alu.sv
// Combinational accumulator update; opcodes that do not touch AC pass it through unchanged.
module dunc16_alu
    import dunc16_pkg::*;
(
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] md,
    output logic [DATA_W-1:0] next_ac
);

    always_comb begin
        next_ac = ac;
        case (opcode)
            OpLda:   next_ac = md;
            OpAdd:   next_ac = ac + md;
            OpSub:   next_ac = ac - md;
            OpAnd:   next_ac = ac & md;
            OpOr:    next_ac = ac | md;
            OpNot:   next_ac = ~ac;
            OpCla:   next_ac = '0;
            default: next_ac = ac;
        endcase
    end

endmodule

// File: rtl/dunc16_core.sv
// NICNAC16 accumulator core driven by an external FETCH/EXECUTE and T0-T3 sequencer.
// Define DUNC16_MEMINIT_EN to power the internal memory up with the demo program.
module dunc16_core
    import dunc16_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FETCH,
    input  logic              EXECUTE,
    input  logic              T0,
    input  logic              T1,
    input  logic              T2,
    input  logic              T3,
    output logic              I_STA,
    output logic              SETWRITE,
    output logic              CLRWRITE,
    output logic [DATA_W-1:0] AC_OUT,
    output logic [DATA_W-1:0] MD_OUT
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef DUNC16_MEMINIT_EN
    logic [DATA_W-1:0] mem [DEPTH] = '{
        0: 16'h1010, 1: 16'h3011, 2: 16'h2012, 3: 16'h8000,
        16: 16'h0005, 17: 16'h0003, default: 16'h0000
    };
`else
    logic [DATA_W-1:0] mem [DEPTH] = '{default: 16'h0000};
`endif

    logic [ADDR_W-1:0] pc, ma;
    logic [DATA_W-1:0] md, ir, ac;
    logic              write_flag;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] alu_ac;
    logic              jump_taken;
    logic              mem_we;
    logic              unused_ir;

    assign opcode    = ir[OP_MSB:OP_LSB];
    assign addr      = ir[ADDR_W-1:0];
    assign unused_ir = ^ir[OP_LSB-1:ADDR_W];

    assign jump_taken = (opcode == OpJmp) ||
                        ((opcode == OpJz) && (ac == '0)) ||
                        ((opcode == OpJn) && ac[DATA_W-1]);

    dunc16_alu u_alu (
        .opcode  (opcode),
        .ac      (ac),
        .md      (md),
        .next_ac (alu_ac)
    );

    // FETCH beats EXECUTE and the lowest-numbered strobe beats the rest.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc         <= '0;
            ma         <= '0;
            md         <= '0;
            ir         <= '0;
            ac         <= '0;
            write_flag <= 1'b0;
        end else if (FETCH) begin
            if (T0) begin
                ma <= pc;
            end else if (T1) begin
                md <= mem[ma];
                pc <= pc + ADDR_W'(1);
            end else if (T2) begin
                ir <= md;
            end
        end else if (EXECUTE) begin
            if (T0) begin
                ma <= addr;
            end else if (T1) begin
                if (reads_mem(opcode)) begin
                    md <= mem[ma];
                end else if (opcode == OpSta) begin
                    md         <= ac;
                    write_flag <= 1'b1;
                end
            end else if (T2) begin
                ac <= alu_ac;
                if (jump_taken) pc <= addr;
            end else if (T3) begin
                write_flag <= 1'b0;
            end
        end
    end

    // Store lands in execute T2, qualified by the flag raised in T1.
    assign mem_we = EXECUTE && !FETCH && T2 && !T1 && !T0 && write_flag;

    always_ff @(posedge CLK) begin
        if (mem_we) mem[ma] <= md;
    end

    assign I_STA    = (opcode == OpSta);
    assign SETWRITE = EXECUTE & T1 & I_STA;
    assign CLRWRITE = EXECUTE & T3 & I_STA;
    assign AC_OUT   = ac;
    assign MD_OUT   = md;

endmodule

// File: tb/tb_dunc16_core.sv
// Bench for dunc16_core: demo program, reset abort of a store, and randomized programs
// checked against an instruction-level model of the machine.
module tb_dunc16_core;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        FETCH = 1'b0;
    logic        EXECUTE = 1'b0;
    logic        T0 = 1'b0, T1 = 1'b0, T2 = 1'b0, T3 = 1'b0;
    logic        I_STA, SETWRITE, CLRWRITE;
    logic [15:0] AC_OUT, MD_OUT;

    dunc16_core #(.ADDR_W(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .FETCH    (FETCH),
        .EXECUTE  (EXECUTE),
        .T0       (T0),
        .T1       (T1),
        .T2       (T2),
        .T3       (T3),
        .I_STA    (I_STA),
        .SETWRITE (SETWRITE),
        .CLRWRITE (CLRWRITE),
        .AC_OUT   (AC_OUT),
        .MD_OUT   (MD_OUT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Instruction-level model state.
    logic [15:0] m_mem [256];
    logic [7:0]  m_pc;
    logic [15:0] m_ac, m_md, m_ir;
    bit          noisy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic f, input logic e, input logic [3:0] t);
        FETCH   = f;
        EXECUTE = e;
        {T3, T2, T1, T0} = t;
    endtask

    // One phase of the major cycle; noisy mode adds higher strobes, EXECUTE during
    // fetch and idle cycles, none of which may change the architectural result.
    task automatic phase(input logic f, input logic e, input int k);
        logic [3:0] t;
        logic [3:0] hi;
        logic       ee;
        logic       sta;
        t  = 4'(1 << k);
        hi = 4'hF << (k + 1);
        ee = e;
        if (noisy) begin
            t = t | (4'($urandom) & hi);
            if (f) ee = 1'($urandom);
        end
        drive(f, ee, t);
        #1;
        sta = (m_ir[15:12] == 4'h2);
        check_eq("setwrite", SETWRITE, ee & t[1] & sta);
        check_eq("clrwrite", CLRWRITE, ee & t[3] & sta);
        edge_step();
        if (noisy && $urandom_range(3) == 0) begin
            if ($urandom_range(1) == 0) drive(1'b0, 1'b0, 4'($urandom));
            else drive(f, e, 4'h0);
            edge_step();
        end
        drive(1'b0, 1'b0, 4'h0);
    endtask

    task automatic run_instr();
        logic [15:0] ir;
        logic [7:0]  a;
        ir = m_mem[m_pc];
        a  = ir[7:0];
        phase(1'b1, 1'b0, 0);
        phase(1'b1, 1'b0, 1);
        check_eq("fetch_md", MD_OUT, ir);
        phase(1'b1, 1'b0, 2);
        m_ir = ir;
        check_eq("i_sta", I_STA, ir[15:12] == 4'h2);
        phase(1'b1, 1'b0, 3);
        m_pc = m_pc + 8'd1;
        m_md = ir;
        case (ir[15:12])
            4'h1: begin m_md = m_mem[a]; m_ac = m_md; end
            4'h2: begin m_md = m_ac; m_mem[a] = m_ac; end
            4'h3: begin m_md = m_mem[a]; m_ac = m_ac + m_md; end
            4'h4: begin m_md = m_mem[a]; m_ac = m_ac - m_md; end
            4'h5: begin m_md = m_mem[a]; m_ac = m_ac & m_md; end
            4'h6: begin m_md = m_mem[a]; m_ac = m_ac | m_md; end
            4'h7: m_ac = ~m_ac;
            4'h8: m_pc = a;
            4'h9: if (m_ac == 16'h0) m_pc = a;
            4'hA: if (m_ac[15]) m_pc = a;
            4'hB: m_ac = 16'h0;
            default: ;
        endcase
        for (int k = 0; k < 4; k++) phase(1'b0, 1'b1, k);
        check_eq("exec_ac", AC_OUT, m_ac);
        check_eq("exec_md", MD_OUT, m_md);
    endtask

    task automatic load_mem();
        for (int i = 0; i < 256; i++) dut.mem[i] = m_mem[i];
    endtask

    task automatic load_demo();
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0;
        m_mem[0]  = 16'h1010;
        m_mem[1]  = 16'h3011;
        m_mem[2]  = 16'h2012;
        m_mem[3]  = 16'h8000;
        m_mem[16] = 16'h0005;
        m_mem[17] = 16'h0003;
        load_mem();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 4'h0);
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        m_pc = 8'h0;
        m_ac = 16'h0;
        m_md = 16'h0;
        m_ir = 16'h0;
    endtask

    initial begin
        #1;
`ifdef DUNC16_MEMINIT_EN
        check_eq("pwrup_m0", dut.mem[0], 16'h1010);
        check_eq("pwrup_m11", dut.mem[17], 16'h0003);
        check_eq("pwrup_m5", dut.mem[5], 16'h0000);
`else
        check_eq("pwrup_m0", dut.mem[0], 16'h0000);
        check_eq("pwrup_m11", dut.mem[17], 16'h0000);
`endif

        // Demo program.
        load_demo();
        do_reset();
        check_eq("rst_ac", AC_OUT, 16'h0);
        check_eq("rst_md", MD_OUT, 16'h0);
        check_eq("rst_i_sta", I_STA, 1'b0);
        check_eq("rst_setwrite", SETWRITE, 1'b0);
        check_eq("rst_clrwrite", CLRWRITE, 1'b0);
        run_instr();
        check_eq("lda_ac", AC_OUT, 16'h0005);
        check_eq("lda_md", MD_OUT, 16'h0005);
        run_instr();
        check_eq("add_md", MD_OUT, 16'h0003);
        check_eq("add_ac", AC_OUT, 16'h0008);
        run_instr();
        check_eq("sta_md", MD_OUT, 16'h0008);
        check_eq("sta_mem", dut.mem[18], 16'h0008);
        run_instr();
        run_instr();
        check_eq("jmp_reload_ac", AC_OUT, 16'h0005);

        // Hold: no strobes or no major state leaves everything alone.
        drive(1'b0, 1'b0, 4'hF);
        edge_step();
        drive(1'b1, 1'b1, 4'h0);
        edge_step();
        drive(1'b0, 1'b0, 4'h0);
        check_eq("hold_ac", AC_OUT, 16'h0005);
        check_eq("hold_md", MD_OUT, 16'h0005);

        // Reset during execute T1 of the store.
        load_demo();
        do_reset();
        run_instr();
        run_instr();
        phase(1'b1, 1'b0, 0);
        phase(1'b1, 1'b0, 1);
        phase(1'b1, 1'b0, 2);
        m_ir = m_mem[2];
        phase(1'b1, 1'b0, 3);
        phase(1'b0, 1'b1, 0);
        drive(1'b0, 1'b1, 4'b0010);
        RESET = 1'b1;
        #1;
        check_eq("abort_ac", AC_OUT, 16'h0);
        check_eq("abort_setwrite", SETWRITE, 1'b0);
        edge_step();
        RESET = 1'b0;
        m_pc = 8'h0;
        m_ac = 16'h0;
        m_md = 16'h0;
        m_ir = 16'h0;
        phase(1'b0, 1'b1, 2);
        phase(1'b0, 1'b1, 3);
        check_eq("abort_write", dut.write_flag, 1'b0);
        check_eq("abort_mem", dut.mem[18], 16'h0000);
        check_eq("abort_ac2", AC_OUT, 16'h0);
        run_instr();
        check_eq("abort_restart_ac", AC_OUT, 16'h0005);

        // Random programs with noisy sequencing.
        for (int trial = 0; trial < 4; trial++) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 16'($urandom);
            load_mem();
            do_reset();
            noisy = 1'b1;
            for (int n = 0; n < 150; n++) run_instr();
            noisy = 1'b0;
            for (int i = 0; i < 256; i++) check_eq("rand_mem", dut.mem[i], m_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
